// File: rtl/rotator_pkg.sv
// Shared types and the fixed power-of-two rotation used by every rotator stage.
package rotator_pkg;

  typedef enum logic {ROT_LEFT = 1'b0, ROT_RIGHT = 1'b1} rot_dir_t;

  // Widest word the helper can rotate; a stage zero-extends its N-bit word into this.
  localparam int unsigned ROT_MAX_N = 256;
  typedef logic [ROT_MAX_N-1:0] rot_word_t;

  // Left-rotates the low n bits of data by 2**k: the low slice moves up and
  // the wrapped high slice is joined underneath. n and k are constants at every
  // call site, so this reduces to pure wiring.
  function automatic rot_word_t rotl_pow2(input rot_word_t data, input int unsigned n,
                                          input int unsigned k);
    rot_word_t   mask;
    rot_word_t   lo;
    rot_word_t   hi;
    int unsigned s;
    s    = 32'd1 << k;
    mask = {ROT_MAX_N{1'b1}} >> (ROT_MAX_N - n);
    lo   = (data << s) & mask;
    hi   = (data & mask) >> (n - s);
    return lo | hi;
  endfunction

endpackage

// File: rtl/rotator_stage.sv
// One pipeline slot: conditional left rotation by 2**K, then data/amount/valid registers.
module rotator_stage
  import rotator_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 0,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_data_i,
  input  logic [W-1:0] in_amt_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] out_data_o,
  output logic [W-1:0] out_amt_o
);

  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;
  logic [W-1:0] amt_q, amt_d;
  logic [N-1:0] rot;
  logic         load;

  assign rot = N'(rotl_pow2(rot_word_t'(in_data_i), N, K));

  // A slot refills whenever it is empty or its word moves on this cycle.
  assign load       = ~valid_q | out_ready_i;
  assign in_ready_o = load;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    if (load) begin
      valid_d = in_valid_i;
      // Bubbles leave data untouched so an idle output does not toggle.
      if (in_valid_i) begin
        data_d = in_amt_i[K] ? rot : in_data_i;
        amt_d  = in_amt_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_amt_o   = amt_q;

endmodule

// File: rtl/pipelined_barrel_rotator.sv
// Run-time left/right rotator: log2(N) registered stages with bubble-collapsing valid/ready.
module pipelined_barrel_rotator
  import rotator_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [N-1:0] up_data,
  input  logic [W-1:0] up_amt,
  input  logic         up_dir,
  output logic         down_valid,
  input  logic         down_ready,
  output logic [N-1:0] down_data
);

  logic [W:0]        vld_pipe;
  logic [W:0]        rdy_pipe;
  logic [W:0][N-1:0] dat_pipe;
  logic [W:0][W-1:0] amt_pipe;
  logic [W-1:0]      unused_amt;

  // Right by s equals left by N-s; the W-bit negate wraps s=0 back to 0.
  assign amt_pipe[0] = (rot_dir_t'(up_dir) == ROT_RIGHT) ? -up_amt : up_amt;
  assign vld_pipe[0] = up_valid;
  assign dat_pipe[0] = up_data;
  assign rdy_pipe[W] = down_ready;

  for (genvar k = 0; k < W; k++) begin : g_stage
    rotator_stage #(.N(N), .K(k), .W(W)) u_stage (
      .clk         (clk),
      .rst_n       (rst),
      .in_valid_i  (vld_pipe[k]),
      .in_ready_o  (rdy_pipe[k]),
      .in_data_i   (dat_pipe[k]),
      .in_amt_i    (amt_pipe[k]),
      .out_valid_o (vld_pipe[k+1]),
      .out_ready_i (rdy_pipe[k+1]),
      .out_data_o  (dat_pipe[k+1]),
      .out_amt_o   (amt_pipe[k+1])
    );
  end

  assign unused_amt = amt_pipe[W];
  assign up_ready   = rdy_pipe[0];
  assign down_valid = vld_pipe[W];
  assign down_data  = dat_pipe[W];

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Directed vector table plus hand-written stall/reset sequences for the N=8 rotator.
module tb_pipelined_barrel_rotator;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int NV = 12;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] a;
    logic       dir;
    logic [7:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         up_valid = 1'b0;
  logic         up_ready;
  logic [N-1:0] up_data = '0;
  logic [W-1:0] up_amt = '0;
  logic         up_dir = 1'b0;
  logic         down_valid;
  logic         down_ready = 1'b1;
  logic [N-1:0] down_data;

  int         tests = 0;
  int         fails = 0;
  int         rx_cnt = 0;
  logic       mon_en = 1'b0;
  logic [7:0] exp_q[$];
  vec_t       vecs[NV];

  always #5 clk = ~clk;

  pipelined_barrel_rotator #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_amt     (up_amt),
    .up_dir     (up_dir),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rot_ref(input logic [7:0] d, input int s, input logic dir);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (!dir) r[(i + s) % 8] = d[i];
      else      r[i] = d[(i + s) % 8];
    end
    return r;
  endfunction

  // Single word through an otherwise idle pipe; lat counts cycles from the
  // cycle the word was offered up to the first cycle down_valid is seen.
  task automatic send_one(input logic [7:0] d, input logic [2:0] a, input logic dir,
                          output logic [7:0] got, output int lat);
    int w;
    @(posedge clk); #1;
    up_valid = 1'b1; up_data = d; up_amt = a; up_dir = dir;
    w = 0;
    @(negedge clk);
    while (!up_ready && w < 10) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    up_valid = 1'b0; up_data = ~d; up_amt = ~a; up_dir = ~dir;
    lat = 1;
    while (!down_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    got = down_data;
  endtask

  // Scoreboard: every output handshake must match the oldest accepted word.
  always @(negedge clk) begin
    if (mon_en && down_valid && down_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %0h with nothing outstanding", down_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (down_data !== e) begin
          fails++;
          $display("FAIL stream_data: got %0h expected %0h", down_data, e);
        end
      end
      rx_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat, stalls, w, nsent, cnt, rx0;
    logic       accepted;
    logic [7:0] got, d, r1, r2;
    logic [7:0] sd[4];
    logic [2:0] sa[4];
    logic       sdir[4];

    vecs[0]  = '{8'hA1, 3'd3, 1'b0, 8'h0D};
    vecs[1]  = '{8'hA1, 3'd3, 1'b1, 8'h34};
    vecs[2]  = '{8'hA1, 3'd0, 1'b0, 8'hA1};
    vecs[3]  = '{8'hA1, 3'd0, 1'b1, 8'hA1};
    vecs[4]  = '{8'h80, 3'd1, 1'b0, 8'h01};
    vecs[5]  = '{8'h01, 3'd1, 1'b1, 8'h80};
    vecs[6]  = '{8'h01, 3'd7, 1'b0, 8'h80};
    vecs[7]  = '{8'hF0, 3'd4, 1'b1, 8'h0F};
    vecs[8]  = '{8'h5A, 3'd2, 1'b0, 8'h69};
    vecs[9]  = '{8'h3C, 3'd5, 1'b1, 8'hE1};
    vecs[10] = '{8'h96, 3'd6, 1'b0, 8'hA5};
    vecs[11] = '{8'h01, 3'd7, 1'b1, 8'h02};

    // Reset state, then ready in the first cycle after release.
    repeat (2) @(negedge clk);
    check("rst_down_valid", 32'(down_valid), 32'd0);
    check("rst_down_data", 32'(down_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_up_ready", 32'(up_ready), 32'd1);

    // Directed vectors: data and latency.
    for (int i = 0; i < NV; i++) begin
      send_one(vecs[i].d, vecs[i].a, vecs[i].dir, got, lat);
      check($sformatf("vec%0d_data", i), 32'(got), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Left by s undone by right by s.
    for (int s = 0; s < 8; s++) begin
      d = 8'hB4 + 8'(s * 29);
      send_one(d, 3'(s), 1'b0, r1, lat);
      check($sformatf("inv%0d_left", s), 32'(r1), 32'(rot_ref(d, s, 1'b0)));
      send_one(r1, 3'(s), 1'b1, r2, lat);
      check($sformatf("inv%0d_back", s), 32'(r2), 32'(d));
    end
    repeat (2) @(posedge clk); #1;

    // Full sweep, back to back, one word per cycle.
    mon_en = 1'b1; rx_cnt = 0; stalls = 0;
    for (int i = 0; i < 4096; i++) begin
      accepted = 1'b0; w = 0;
      while (!accepted && w < 8) begin
        @(posedge clk); #1;
        up_valid = 1'b1; up_data = i[7:0]; up_amt = i[10:8]; up_dir = i[11];
        @(negedge clk);
        if (up_ready) begin
          exp_q.push_back(rot_ref(i[7:0], int'(i[10:8]), i[11]));
          accepted = 1'b1;
        end else stalls++;
        w++;
      end
    end
    @(posedge clk); #1;
    up_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("sweep_stalls", 32'(stalls), 32'd0);
    check("sweep_count", 32'(rx_cnt), 32'd4096);
    check("sweep_drained", 32'(exp_q.size()), 32'd0);

    // Stall: capacity is exactly W words, output held stable.
    sd[0] = 8'h11; sd[1] = 8'hC3; sd[2] = 8'h7E; sd[3] = 8'h29;
    sa[0] = 3'd1;  sa[1] = 3'd5;  sa[2] = 3'd2;  sa[3] = 3'd6;
    sdir[0] = 1'b0; sdir[1] = 1'b1; sdir[2] = 1'b1; sdir[3] = 1'b0;
    down_ready = 1'b0; nsent = 0; rx0 = rx_cnt;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      up_valid = 1'b1; up_data = sd[nsent]; up_amt = sa[nsent]; up_dir = sdir[nsent];
      @(negedge clk);
      if (up_ready) begin
        exp_q.push_back(rot_ref(sd[nsent], int'(sa[nsent]), sdir[nsent]));
        nsent++;
      end
    end
    check("stall_accepted", 32'(nsent), 32'd3);
    check("stall_up_ready", 32'(up_ready), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_hold_valid", 32'(down_valid), 32'd1);
      check("stall_hold_data", 32'(down_data), 32'(rot_ref(sd[0], int'(sa[0]), sdir[0])));
    end
    // Resume with a word waiting: ready returns in the same cycle.
    @(posedge clk); #1;
    down_ready = 1'b1;
    @(negedge clk);
    check("resume_up_ready", 32'(up_ready), 32'd1);
    if (up_ready) exp_q.push_back(rot_ref(sd[3], int'(sa[3]), sdir[3]));
    @(posedge clk); #1;
    up_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("stall_rx_count", 32'(rx_cnt - rx0), 32'd4);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two words in flight.
    mon_en = 1'b0;
    down_ready = 1'b0;
    @(posedge clk); #1;
    up_valid = 1'b1; up_data = 8'hDE; up_amt = 3'd1; up_dir = 1'b0;
    @(posedge clk); #1;
    up_data = 8'hAD; up_amt = 3'd2;
    @(posedge clk); #1;
    up_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(down_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_reset_valid", 32'(down_valid), 32'd0);
    check("mid_reset_data", 32'(down_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    down_ready = 1'b1;
    @(negedge clk);
    check("rerst_up_ready", 32'(up_ready), 32'd1);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (down_valid) cnt++;
    end
    check("post_reset_stale", 32'(cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_rotator.md
# pipelined_barrel_rotator

- Rotates an N-bit word by a run-time amount, left or right, through a log2(N)-stage register pipeline with valid/ready flow control.
- It is the dynamic, bidirectional counterpart of the constant-amount circular shifters in the arithmetics/pipelining chapter.
- It feeds datapaths that need variable rotation at full throughput: hash mixing, CRC alignment, and decoders that undo a rotation applied by an encoder.

## Interface
Parameters:
- N, 8, data width; power of two, N >= 2.
- W (localparam), $clog2(N), width of the amount and number of pipeline stages (L = W).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- up_valid  input  1  input word present.
- up_ready  output  1  block accepts the input word this cycle.
- up_data  input  N  word to rotate.
- up_amt  input  W  rotation amount, 0..N-1.
- up_dir  input  1  0 = rotate left, 1 = rotate right.
- down_valid  output  1  result present.
- down_ready  input  1  consumer accepts the result.
- down_data  output  N  rotated word.

## Operation
Direction semantics:
- Rotate right by s is ABCDEFGH -> FGHABCDE for N=8, s=3.
- Rotate left by s is ABCDEFGH -> DEFGHABC.

Input normalisation (combinational, before stage 0):
- Right rotation is converted to left rotation: eff = up_dir ? (N - up_amt) mod N : up_amt.
- Computed in W bits: eff = -up_amt when up_dir = 1. Wrap-around is intrinsic to the width.
- up_amt = 0 gives pass-through in both directions.

Stage k (k = 0..W-1):
- Rotates its data left by 2^k if bit k of the carried amount is 1; otherwise passes data unchanged.
- Registers data, remaining amount bits, and a valid bit.

Flow control (per-stage bubble-collapsing):
- stage k loads when valid[k] = 0 or stage k advances.
- The last stage advances when down_ready = 1.
- Stage k < W-1 advances when stage k+1 loads.
- up_ready = stage 0 loads.
- A transfer on either side occurs only when valid and ready are both 1 in the same cycle.

Output mapping:
- down_valid = valid[W-1].
- down_data = data register of stage W-1.
- No combinational path from up_* to down_*.

Reset:
- All valid bits go to 0, so down_valid = 0.
- All data and amount registers go to 0, so down_data = 0.
- up_ready = 1 in the first cycle after reset release.
- Reset asserted mid-operation discards in-flight words with no partial output.

## Timing
- Latency: W cycles from input handshake to down_valid = 1 when down_ready stays 1 (3 cycles for N=8).
- Throughput: one word per cycle when unstalled.
- Stall: while down_valid = 1 and down_ready = 0, down_data is held stable.
  - Upstream stages keep filling bubbles.
  - up_ready drops only when all W stages hold valid words.
  - Capacity is W words; nothing is lost or duplicated.
- Resume:
  - The first cycle down_ready = 1 retires the head word.
  - up_ready returns to 1 in that same cycle, through the combinational ready chain.
- Simultaneous output retire and input accept in a full pipeline is legal and keeps occupancy at W.
- An input word is sampled only on an up handshake; up_data, up_amt and up_dir are don't-care otherwise.

## Structure
- Package rotator_pkg holds:
  - typedef enum logic {ROT_LEFT = 1'b0, ROT_RIGHT = 1'b1} rot_dir_t, used for up_dir.
  - a function rotl_pow2(data, k) giving the fixed left rotation by 2^k, written as slice concatenation.
- Sub-module rotator_stage #(N, K):
  - one pipeline slot containing the conditional 2^K rotation, data/amount/valid registers and the local ready logic.
  - the top generates W instances and chains their valid/ready signals.

## Test plan
N=8 throughout.
- Reset, then send up_data=8'hA1, up_amt=3, up_dir=0 -> down_data=8'h0D with down_valid after 3 cycles; down_data=0 and down_valid=0 during reset.
- up_data=8'hA1, up_amt=3, up_dir=1 -> down_data=8'h34; up_amt=0 in either direction -> 8'hA1.
- Sweep all 256 data values × 8 amounts × 2 directions back-to-back with down_ready=1 -> one result per cycle, in order, each matching a reference model.
- Send a left rotate by s, then a right rotate by s of that result -> original word recovered for every s.
- Hold down_ready=0 while streaming -> up_ready falls after exactly 3 accepted words and down_data stays stable; release down_ready -> 3 words emerge in order, with no loss or duplication.
- Assert rst with 2 words in flight -> down_valid=0 immediately; after release, the pipeline is empty and no stale word ever appears.
